// File: rtl/aha_clock_switch_defs.vh
// Shared encodings and widths for the clock-switch controller and its bench-facing ports.
`ifndef AHA_CLOCK_SWITCH_DEFS_VH
`define AHA_CLOCK_SWITCH_DEFS_VH

`define AHA_CS_ST_W        2
`define AHA_CS_ST_IDLE     2'd0
`define AHA_CS_ST_DESELECT 2'd1
`define AHA_CS_ST_SELECT   2'd2
`define AHA_CS_ST_DONE     2'd3

`define AHA_CS_SEL_W       3
`define AHA_CS_CNT_W       8

`endif

// File: rtl/aha_sync_bit.sv
// Two-flop synchronizer for one asynchronous level into the clk domain.
// Latency 2 clk edges; no handshake, input is a level and may change at any time.
module aha_sync_bit (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/aha_clock_switch_ctrl.sv
// Break-before-make sequencer across NUM_CLK glitch-free clock-switch slices.
// Ack >= 7 CLK after capture for healthy slices (1 CLK for no-op/bad index); REQ/ACK level handshake with the platform.
`include "aha_clock_switch_defs.vh"

module aha_clock_switch_ctrl #(
    parameter int NUM_CLK        = 4,
    parameter int RESET_SEL      = 0,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                     CLK,
    input  logic                     RESETn,
    input  logic                     SWITCH_REQ,
    input  logic [`AHA_CS_SEL_W-1:0] SWITCH_SEL,
    input  logic [NUM_CLK-1:0]       SELECT_ACK,
    output logic [NUM_CLK-1:0]       SELECT_REQ,
    output logic                     SWITCH_ACK,
    output logic                     SWITCH_ERR,
    output logic [`AHA_CS_SEL_W-1:0] CURRENT_SEL,
    output logic                     BUSY
);

    localparam logic [NUM_CLK-1:0]       RESET_VEC    = {{(NUM_CLK-1){1'b0}}, 1'b1} << RESET_SEL;
    localparam logic [`AHA_CS_SEL_W-1:0] RESET_IDX    = `AHA_CS_SEL_W'(RESET_SEL);
    localparam logic [`AHA_CS_CNT_W-1:0] TIMEOUT_LAST = `AHA_CS_CNT_W'(TIMEOUT_CYCLES - 1);

    logic [`AHA_CS_ST_W-1:0]  state_q, state_d;
    logic [`AHA_CS_SEL_W-1:0] tgt_q, tgt_d;
    logic [`AHA_CS_SEL_W-1:0] cur_q, cur_d;
    logic [NUM_CLK-1:0]       req_q, req_d;
    logic                     ack_q, ack_d;
    logic                     err_q, err_d;
    logic [`AHA_CS_CNT_W-1:0] cnt_q, cnt_d;
    logic [NUM_CLK-1:0]       ack_s;

    logic sel_valid;
    logic cur_ack;
    logic tgt_ack;
    logic timed_out;

    function automatic logic [NUM_CLK-1:0] decode(input logic [`AHA_CS_SEL_W-1:0] idx);
        logic [NUM_CLK-1:0] v;
        v = '0;
        for (int i = 0; i < NUM_CLK; i++) begin
            if (idx == `AHA_CS_SEL_W'(i)) v[i] = 1'b1;
        end
        return v;
    endfunction

    for (genvar i = 0; i < NUM_CLK; i++) begin : g_sync
        aha_sync_bit u_sync (
            .clk   (CLK),
            .rst_n (RESETn),
            .d     (SELECT_ACK[i]),
            .q     (ack_s[i])
        );
    end

    assign sel_valid = int'(SWITCH_SEL) < NUM_CLK;
    assign cur_ack   = |(ack_s & decode(cur_q));
    assign tgt_ack   = |(ack_s & decode(tgt_q));
    assign timed_out = (cnt_q == TIMEOUT_LAST);

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state_q <= `AHA_CS_ST_IDLE;
            tgt_q   <= RESET_IDX;
            cur_q   <= RESET_IDX;
            req_q   <= RESET_VEC;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            tgt_q   <= tgt_d;
            cur_q   <= cur_d;
            req_q   <= req_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            `AHA_CS_ST_IDLE: begin
                if (SWITCH_REQ) begin
                    if (!sel_valid || SWITCH_SEL == cur_q) state_d = `AHA_CS_ST_DONE;
                    else                                    state_d = `AHA_CS_ST_DESELECT;
                end
            end
            `AHA_CS_ST_DESELECT: begin
                if (!cur_ack)       state_d = `AHA_CS_ST_SELECT;
                else if (timed_out) state_d = `AHA_CS_ST_DONE;
            end
            `AHA_CS_ST_SELECT: begin
                if (tgt_ack || timed_out) state_d = `AHA_CS_ST_DONE;
            end
            `AHA_CS_ST_DONE: begin
                if (!SWITCH_REQ) state_d = `AHA_CS_ST_IDLE;
            end
            default: state_d = `AHA_CS_ST_IDLE;
        endcase
    end

    // Next values for the registered outputs; the old slice's request only
    // comes back if its ack never fell, so no two requests overlap.
    always_comb begin
        tgt_d = tgt_q;
        cur_d = cur_q;
        req_d = req_q;
        err_d = err_q;
        cnt_d = cnt_q;
        ack_d = (state_q == `AHA_CS_ST_DONE) && SWITCH_REQ;
        case (state_q)
            `AHA_CS_ST_IDLE: begin
                if (SWITCH_REQ) begin
                    tgt_d = SWITCH_SEL;
                    err_d = !sel_valid;
                    if (sel_valid && SWITCH_SEL != cur_q) begin
                        req_d = req_q & ~decode(cur_q);
                        cnt_d = '0;
                    end
                end
            end
            `AHA_CS_ST_DESELECT: begin
                if (!cur_ack) begin
                    req_d = decode(tgt_q);
                    cnt_d = '0;
                end else if (timed_out) begin
                    req_d = req_q | decode(cur_q);
                    err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            `AHA_CS_ST_SELECT: begin
                if (tgt_ack) begin
                    cur_d = tgt_q;
                    err_d = 1'b0;
                end else if (timed_out) begin
                    cur_d = tgt_q;
                    err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign SELECT_REQ  = req_q;
    assign SWITCH_ACK  = ack_q;
    assign SWITCH_ERR  = err_q;
    assign CURRENT_SEL = cur_q;
    assign BUSY        = (state_q != `AHA_CS_ST_IDLE);

endmodule

// File: tb/tb_aha_clock_switch_ctrl.sv
// Randomized and directed bench for aha_clock_switch_ctrl against a transaction-level outcome model.
module tb_aha_clock_switch_ctrl;

    localparam int N  = 4;
    localparam int T  = 255;
    localparam int RS = 0;

    logic         CLK        = 1'b0;
    logic         RESETn     = 1'b0;
    logic         SWITCH_REQ = 1'b0;
    logic [2:0]   SWITCH_SEL = 3'd0;
    logic [N-1:0] SELECT_ACK = '0;
    logic [N-1:0] SELECT_REQ;
    logic         SWITCH_ACK;
    logic         SWITCH_ERR;
    logic [2:0]   CURRENT_SEL;
    logic         BUSY;

    int   nchk = 0;
    int   nerr = 0;
    int   model_cur = RS;
    logic model_err = 1'b0;
    int   mode [N];          // 0 healthy (ack = req delayed), 1 stuck low, 2 stuck high
    logic [2:0] pipe [N];
    logic [N-1:0] last_req = 4'b0001;
    logic [N-1:0] req_trace [$];

    aha_clock_switch_ctrl #(.NUM_CLK(N), .RESET_SEL(RS), .TIMEOUT_CYCLES(T)) dut (
        .CLK         (CLK),
        .RESETn      (RESETn),
        .SWITCH_REQ  (SWITCH_REQ),
        .SWITCH_SEL  (SWITCH_SEL),
        .SELECT_ACK  (SELECT_ACK),
        .SELECT_REQ  (SELECT_REQ),
        .SWITCH_ACK  (SWITCH_ACK),
        .SWITCH_ERR  (SWITCH_ERR),
        .CURRENT_SEL (CURRENT_SEL),
        .BUSY        (BUSY)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [N-1:0] oh(input int i);
        logic [N-1:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // Outcome of one request from the slice behaviour alone.
    function automatic void predict(input int cur, input int sel, output int ncur,
                                    output logic err, output int kind);
        if (sel >= N)            begin ncur = cur; err = 1'b1; kind = 0; end
        else if (sel == cur)     begin ncur = cur; err = 1'b0; kind = 0; end
        else if (mode[cur] == 2) begin ncur = cur; err = 1'b1; kind = 2; end
        else if (mode[sel] == 1) begin ncur = sel; err = 1'b1; kind = 2; end
        else                     begin ncur = sel; err = 1'b0; kind = 1; end
    endfunction

    // Slice model: ack follows its request about three cycles later.
    always @(negedge CLK) begin
        for (int i = 0; i < N; i++) begin
            pipe[i] = {pipe[i][1:0], SELECT_REQ[i]};
            case (mode[i])
                1:       SELECT_ACK[i] = 1'b0;
                2:       SELECT_ACK[i] = 1'b1;
                default: SELECT_ACK[i] = pipe[i][2];
            endcase
        end
    end

    always @(negedge CLK) begin
        if (RESETn) begin
            if (SELECT_REQ !== last_req) begin
                req_trace.push_back(SELECT_REQ);
                last_req = SELECT_REQ;
            end
            check("req_onehot", $countones(SELECT_REQ) <= 1, 1);
            if (SWITCH_ACK) begin
                check("ack_err", SWITCH_ERR, model_err);
                check("ack_cur", CURRENT_SEL, model_cur);
                check("ack_req", SELECT_REQ, oh(model_cur));
            end
            if (!BUSY && !SWITCH_REQ) begin
                check("idle_cur", CURRENT_SEL, model_cur);
                check("idle_req", SELECT_REQ, oh(model_cur));
                check("idle_err", SWITCH_ERR, model_err);
                check("idle_ack", SWITCH_ACK, 0);
            end
        end
    end

    task automatic do_switch(input int sel, input bit drop_early);
        int   pcur, pkind, n;
        logic perr;
        bit   healthy;
        predict(model_cur, sel, pcur, perr, pkind);
        healthy = (mode[model_cur] == 0) && (sel >= N || mode[sel] == 0);
        @(posedge CLK); #1;
        SWITCH_SEL = 3'(sel);
        SWITCH_REQ = 1'b1;
        n = 0;
        while (!BUSY && n < 4) begin @(posedge CLK); #1; n++; end
        check("busy_rise", BUSY, 1);
        model_cur = pcur;
        model_err = perr;
        SWITCH_SEL = 3'($urandom_range(0, 7));
        if (drop_early) begin
            SWITCH_REQ = 1'b0;
            n = 0;
            while (BUSY && n < 700) begin @(posedge CLK); #1; n++; end
            check("busy_fall_early", BUSY, 0);
        end else begin
            n = 0;
            while (!SWITCH_ACK && n < 700) begin @(posedge CLK); #1; n++; end
            check("ack_rise", SWITCH_ACK, 1);
            case (pkind)
                0: check("lat_quick", n, 1);
                1: begin
                    if (healthy) check("lat_min", n >= 7, 1);
                    check("lat_max", n <= 30, 1);
                end
                default: begin
                    check("lat_to_min", n >= T, 1);
                    check("lat_to_max", n <= T + 30, 1);
                end
            endcase
            SWITCH_REQ = 1'b0;
            n = 0;
            while ((SWITCH_ACK || BUSY) && n < 5) begin @(posedge CLK); #1; n++; end
            check("ack_fall", SWITCH_ACK, 0);
            check("busy_fall", BUSY, 0);
        end
        repeat (8) @(posedge CLK);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < N; i++) begin
            mode[i] = 0;
            pipe[i] = 3'b000;
        end
        repeat (3) @(posedge CLK);
        #1;
        check("rst_req", SELECT_REQ, 4'b0001);
        check("rst_cur", CURRENT_SEL, 0);
        check("rst_busy", BUSY, 0);
        check("rst_ack", SWITCH_ACK, 0);
        check("rst_err", SWITCH_ERR, 0);
        RESETn = 1'b1;
        repeat (10) @(posedge CLK);
        #1;
        check("post_rst_req", SELECT_REQ, 4'b0001);
        check("post_rst_cur", CURRENT_SEL, 0);
        check("post_rst_busy", BUSY, 0);

        // Same index: immediate ack, nothing moves
        do_switch(0, 1'b0);
        check("same_req", SELECT_REQ, 4'b0001);
        check("same_err", SWITCH_ERR, 0);

        // 0 -> 2: break before make
        req_trace.delete();
        do_switch(2, 1'b0);
        check("sw2_trace_len", req_trace.size(), 2);
        if (req_trace.size() == 2) begin
            check("sw2_trace0", req_trace[0], 4'b0000);
            check("sw2_trace1", req_trace[1], 4'b0100);
        end
        check("sw2_req", SELECT_REQ, 4'b0100);
        check("sw2_cur", CURRENT_SEL, 2);
        check("sw2_err", SWITCH_ERR, 0);

        // Out-of-range index
        do_switch(5, 1'b0);
        check("bad_err", SWITCH_ERR, 1);
        check("bad_req", SELECT_REQ, 4'b0100);
        check("bad_cur", CURRENT_SEL, 2);

        // New slice never acks: timeout in SELECT, target kept
        mode[1] = 1;
        do_switch(1, 1'b0);
        check("stlo_req", SELECT_REQ, 4'b0010);
        check("stlo_cur", CURRENT_SEL, 1);
        check("stlo_err", SWITCH_ERR, 1);
        mode[1] = 0;
        repeat (8) @(posedge CLK);

        // Old slice never releases: timeout in DESELECT, old bit restored
        mode[1] = 2;
        do_switch(3, 1'b0);
        check("sthi_req", SELECT_REQ, 4'b0010);
        check("sthi_cur", CURRENT_SEL, 1);
        check("sthi_err", SWITCH_ERR, 1);
        mode[1] = 0;
        repeat (8) @(posedge CLK);

        // Reset in the middle of SELECT
        @(posedge CLK); #1;
        SWITCH_SEL = 3'd3;
        SWITCH_REQ = 1'b1;
        repeat (8) @(posedge CLK);
        #1;
        check("mid_busy", BUSY, 1);
        check("mid_req", SELECT_REQ, 4'b1000);
        RESETn = 1'b0;
        #1;
        check("arst_req", SELECT_REQ, 4'b0001);
        check("arst_cur", CURRENT_SEL, 0);
        check("arst_busy", BUSY, 0);
        check("arst_ack", SWITCH_ACK, 0);
        check("arst_err", SWITCH_ERR, 0);
        SWITCH_REQ = 1'b0;
        model_cur = 0;
        model_err = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        RESETn = 1'b1;
        repeat (10) @(posedge CLK);
        do_switch(2, 1'b0);
        check("post_arst_cur", CURRENT_SEL, 2);
        check("post_arst_err", SWITCH_ERR, 0);

        for (int k = 0; k < 40; k++) begin
            int sel;
            int r;
            bit de;
            sel = $urandom_range(0, 5);
            r   = $urandom_range(0, 9);
            if (r == 0) mode[model_cur] = 2;
            else if (r == 1 && sel < N && sel != model_cur) mode[sel] = 1;
            de = ($urandom_range(0, 7) == 0);
            do_switch(sel, de);
            for (int i = 0; i < N; i++) mode[i] = 0;
            repeat (8) @(posedge CLK);
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/aha_clock_switch_ctrl.md
AHA_CLOCK_SWITCH_CTRL -- requirements
Module: aha_clock_switch_ctrl

Interface
REQ-001 Parameter NUM_CLK, default 4, meaning number of clock-switch slices controlled (2..8).
REQ-002 Parameter RESET_SEL, default 0, meaning source index requested out of reset.
REQ-003 Parameter TIMEOUT_CYCLES, default 255, meaning max CLK cycles to wait for a slice acknowledge (1..255).
REQ-004 CLK  input  1  always-on reference clock; all logic on rising edge.
REQ-005 RESETn  input  1  reset, asynchronous assert, active-low.
REQ-006 SWITCH_REQ  input  1  level request from platform controller; held high until SWITCH_ACK.
REQ-007 SWITCH_SEL  input  3  requested source index; stable while SWITCH_REQ high.
REQ-008 SELECT_ACK  input  NUM_CLK  per-slice acknowledge, asynchronous to CLK.
REQ-009 SELECT_REQ  output  NUM_CLK  per-slice select request, at most one bit high.
REQ-010 SWITCH_ACK  output  1  request complete, high until SWITCH_REQ low.
REQ-011 SWITCH_ERR  output  1  last request failed (bad index or timeout); valid while SWITCH_ACK high.
REQ-012 CURRENT_SEL  output  3  index of source currently selected.
REQ-013 BUSY  output  1  high in any state other than IDLE.

Function
REQ-014 SELECT_ACK shall pass through a 2-flop synchronizer per bit; all FSM decisions use synchronized values only.
REQ-015 FSM states: IDLE, DESELECT, SELECT, DONE; registered outputs.
REQ-016 IDLE: on SWITCH_REQ=1, capture SWITCH_SEL into target register; if target>=NUM_CLK go DONE with ERR=1; if target==CURRENT_SEL go DONE with ERR=0; else go DESELECT.
REQ-017 DESELECT: clear SELECT_REQ[CURRENT_SEL] on entry; when synced ACK[CURRENT_SEL]==0 go SELECT.
REQ-018 SELECT: set SELECT_REQ[target] on entry; when synced ACK[target]==1 update CURRENT_SEL=target, go DONE with ERR=0.
REQ-019 No two SELECT_REQ bits shall be high in the same cycle; new bit rises only after old ack observed low.
REQ-020 Timeout counter (8 bits) clears on entry to DESELECT and SELECT, increments each cycle in them; reaching TIMEOUT_CYCLES is a timeout.
REQ-021 DESELECT timeout: re-assert SELECT_REQ[CURRENT_SEL], CURRENT_SEL unchanged, go DONE with ERR=1.
REQ-022 SELECT timeout: keep SELECT_REQ[target] high, CURRENT_SEL=target, go DONE with ERR=1.
REQ-023 DONE: SWITCH_ACK=1; when SWITCH_REQ==0 clear SWITCH_ACK, go IDLE; SWITCH_ERR holds until next capture in IDLE.
REQ-024 Latency, healthy slices: SWITCH_ACK high no earlier than 2 (sync) + 2 (sync) + 3 (state) CLK cycles after capture; same-index request acks 1 cycle after capture.
REQ-025 SWITCH_SEL changes while BUSY are ignored; SWITCH_REQ dropped before DONE does not abort the sequence.

Reset
REQ-026 On RESETn low: state=IDLE, SELECT_REQ=one-hot RESET_SEL, CURRENT_SEL=RESET_SEL, SWITCH_ACK=0, SWITCH_ERR=0, BUSY=0, counter=0, synchronizers=0.
REQ-027 Reset asserted mid-switch returns immediately to REQ-026 values regardless of slice ack state.

Structure
REQ-028 State encodings and width constants in a shared Verilog include file (aha_clock_switch_defs.vh), no SystemVerilog package.
REQ-029 One sub-module: aha_sync_bit (2-flop synchronizer, async active-low reset), instantiated NUM_CLK times.

Verification
REQ-030 Reset, ack model toggles 3 cycles after req: SELECT_REQ=4'b0001, CURRENT_SEL=0, BUSY=0 after release.
REQ-031 REQ sel=2 from 0: SELECT_REQ 0001->0000->0100, never two bits high, SWITCH_ACK=1, ERR=0, CURRENT_SEL=2.
REQ-032 REQ sel=0 while CURRENT_SEL=0: SWITCH_ACK 1 cycle after capture, ERR=0, SELECT_REQ unchanged.
REQ-033 REQ sel=5, NUM_CLK=4: SWITCH_ACK with ERR=1, SELECT_REQ and CURRENT_SEL unchanged.
REQ-034 Slice 1 ack stuck low, REQ sel=1: ERR=1 after 255 cycles in SELECT, SELECT_REQ=0010, CURRENT_SEL=1; old ack stuck high case restores old bit.
REQ-035 RESETn pulsed low during SELECT: outputs return to reset values same cycle, next request completes normally.
